// File: rtl/eu_lsu_arb_pkg.sv
// Shared sizing helpers for the LSU request arbiter and its per-channel FIFOs.
package eu_lsu_arb_pkg;

  // Width of a channel index; at least one bit even for a single channel pair.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/eu_req_fifo.sv
// Per-channel request FIFO: circular buffer with speculative kill by spectag
// mask and automatic removal of killed heads.
module eu_req_fifo
  import eu_lsu_arb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REQ_W  = 128,
  parameter int SPEC_W = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int OCC_W = occ_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [SPEC_W-1:0] kill_mask_i,
  input  logic              push_i,
  input  logic [REQ_W-1:0]  push_data_i,
  input  logic [SPEC_W-1:0] push_spec_i,
  input  logic              pop_i,
  output logic              head_vld_o,
  output logic [REQ_W-1:0]  head_data_o,
  output logic [SPEC_W-1:0] head_spec_o,
  output logic              ready_o,
  output logic [OCC_W-1:0]  count_o
);

  typedef struct packed {
    logic              valid;
    logic [SPEC_W-1:0] spectag;
    logic [REQ_W-1:0]  payload;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             auto_pop, do_pop;

  // A head squashed this very cycle is not offered to the arbiter; it is
  // dropped right away instead, so it never reaches the output register.
  assign head        = mem_q[rd_ptr_q];
  assign head_vld_o  = (count_q != '0) && head.valid && ((head.spectag & kill_mask_i) == '0);
  assign head_data_o = head.payload;
  assign head_spec_o = head.spectag;
  assign auto_pop    = (count_q != '0) && !head_vld_o;
  assign do_pop      = auto_pop | pop_i;
  assign count_d     = count_q + OCC_W'(push_i) - OCC_W'(do_pop);
  assign ready_o     = ready_q;
  assign count_o     = count_q;

  // Storage, pointers and count; ready is registered from the next count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[AW'(i)] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[AW'(i)].valid <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((mem_q[AW'(i)].spectag & kill_mask_i) != '0) mem_q[AW'(i)].valid <= 1'b0;
      end
      if (push_i) begin
        mem_q[wr_ptr_q] <= '{valid:   ((push_spec_i & kill_mask_i) == '0),
                             spectag: push_spec_i,
                             payload: push_data_i};
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != OCC_W'(DEPTH));
    end
  end

endmodule

// File: rtl/eu_lsu_arbiter.sv
// Multi-channel Load/Store FU to LSU arbiter: per-channel FIFOs, round-robin
// selection into a registered request stage, tagged response demultiplexer.
module eu_lsu_arbiter
  import eu_lsu_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int REQ_W   = 128,
  parameter int RESP_W  = 96,
  parameter int DEPTH   = 4,
  parameter int SPEC_W  = 4,
  localparam int CH_W   = ch_w(NUM_CH),
  localparam int OCC_W  = occ_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Flush,
  input  logic [SPEC_W-1:0]        kill_mask,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  output logic [NUM_CH-1:0]        ch_req_ready,
  input  logic [NUM_CH*REQ_W-1:0]  ch_req_data,
  input  logic [NUM_CH*SPEC_W-1:0] ch_req_spectag,
  output logic                     lsu_req_valid,
  input  logic                     lsu_req_ready,
  output logic [REQ_W-1:0]         lsu_req_data,
  output logic [CH_W-1:0]          lsu_req_ch,
  input  logic                     lsu_resp_valid,
  input  logic [CH_W-1:0]          lsu_resp_ch,
  input  logic [RESP_W-1:0]        lsu_resp_data,
  output logic [NUM_CH-1:0]        ch_resp_valid,
  output logic [RESP_W-1:0]        ch_resp_data,
  output logic [NUM_CH*OCC_W-1:0]  ch_occupancy
);

  logic [NUM_CH-1:0] push, pop, head_vld, fifo_ready;
  logic [REQ_W-1:0]  head_data  [NUM_CH];
  logic [SPEC_W-1:0] head_spec  [NUM_CH];
  logic [OCC_W-1:0]  fifo_count [NUM_CH];

  logic              grant_vld, load_en, resp_hit;
  logic [CH_W-1:0]   grant_idx, cand, rr_nxt, rr_ptr_q;
  int                idx;

  logic              out_vld_q;
  logic [REQ_W-1:0]  out_data_q;
  logic [SPEC_W-1:0] out_spec_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [NUM_CH-1:0] resp_vld_q, resp_vld_d;
  logic [RESP_W-1:0] resp_data_q;

  // Output stage takes a new winner when empty or being handed off this cycle.
  assign load_en = ~out_vld_q | lsu_req_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign push[g] = ch_req_valid[g] & fifo_ready[g] & ~Flush;
    assign pop[g]  = load_en & grant_vld & (grant_idx == CH_W'(g)) & ~Flush;
    assign ch_occupancy[g*OCC_W +: OCC_W] = fifo_count[g];

    eu_req_fifo #(
      .DEPTH  (DEPTH),
      .REQ_W  (REQ_W),
      .SPEC_W (SPEC_W)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (Flush),
      .kill_mask_i (kill_mask),
      .push_i      (push[g]),
      .push_data_i (ch_req_data[g*REQ_W +: REQ_W]),
      .push_spec_i (ch_req_spectag[g*SPEC_W +: SPEC_W]),
      .pop_i       (pop[g]),
      .head_vld_o  (head_vld[g]),
      .head_data_o (head_data[g]),
      .head_spec_o (head_spec[g]),
      .ready_o     (fifo_ready[g]),
      .count_o     (fifo_count[g])
    );
  end

  // Round-robin pick: scan from farthest to nearest so the channel closest to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (head_vld[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    rr_nxt = ((int'(grant_idx) + 1) >= NUM_CH) ? '0 : grant_idx + 1'b1;
  end

  // Registered LSU request stage and round-robin pointer (pointer survives flush).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_spec_q <= '0;
      out_ch_q   <= '0;
      rr_ptr_q   <= '0;
    end else if (Flush) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_spec_q <= '0;
      out_ch_q   <= '0;
    end else if (load_en) begin
      out_vld_q <= grant_vld;
      if (grant_vld) begin
        out_data_q <= head_data[grant_idx];
        out_spec_q <= head_spec[grant_idx];
        out_ch_q   <= grant_idx;
        rr_ptr_q   <= rr_nxt;
      end
    end else if ((out_spec_q & kill_mask) != '0) begin
      out_vld_q <= 1'b0;
    end
  end

  assign resp_hit   = lsu_resp_valid && (int'(lsu_resp_ch) < NUM_CH);
  assign resp_vld_d = resp_hit ? ({{(NUM_CH-1){1'b0}}, 1'b1} << lsu_resp_ch) : '0;

  // Response register: one-cycle one-hot strobe, payload broadcast to all channels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_vld_q  <= '0;
      resp_data_q <= '0;
    end else if (Flush) begin
      resp_vld_q  <= '0;
      resp_data_q <= '0;
    end else begin
      resp_vld_q <= resp_vld_d;
      if (resp_hit) resp_data_q <= lsu_resp_data;
    end
  end

  assign ch_req_ready  = fifo_ready;
  assign lsu_req_valid = out_vld_q;
  assign lsu_req_data  = out_data_q;
  assign lsu_req_ch    = out_ch_q;
  assign ch_resp_valid = resp_vld_q;
  assign ch_resp_data  = resp_data_q;

endmodule

// File: tb/tb_eu_lsu_arbiter.sv
// Scoreboard bench for eu_lsu_arbiter (2-channel main instance, 3-channel
// instance for out-of-range response tags).
module tb_eu_lsu_arbiter;

  logic         clk, rst, Flush;
  logic [3:0]   kill_mask;
  logic [1:0]   ch_req_valid, ch_req_ready;
  logic [255:0] ch_req_data;
  logic [7:0]   ch_req_spectag;
  logic         lsu_req_valid, lsu_req_ready;
  logic [127:0] lsu_req_data;
  logic [0:0]   lsu_req_ch;
  logic         lsu_resp_valid;
  logic [0:0]   lsu_resp_ch;
  logic [95:0]  lsu_resp_data;
  logic [1:0]   ch_resp_valid;
  logic [95:0]  ch_resp_data;
  logic [5:0]   ch_occupancy;

  logic [2:0]   t3_req_valid, t3_req_ready, t3_resp_valid;
  logic [383:0] t3_req_data;
  logic [11:0]  t3_req_spectag;
  logic         t3_lsu_valid, t3_lsu_ready, t3_lsu_resp_valid;
  logic [127:0] t3_lsu_data;
  logic [1:0]   t3_lsu_ch, t3_lsu_resp_ch;
  logic [95:0]  t3_lsu_resp_data, t3_resp_data;
  logic [8:0]   t3_occupancy;

  typedef struct {
    logic [0:0]   ch;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   accepted;

  eu_lsu_arbiter dut (
    .clk(clk), .rst(rst), .Flush(Flush), .kill_mask(kill_mask),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_req_data(ch_req_data), .ch_req_spectag(ch_req_spectag),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_data(lsu_req_data), .lsu_req_ch(lsu_req_ch),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ch(lsu_resp_ch),
    .lsu_resp_data(lsu_resp_data), .ch_resp_valid(ch_resp_valid),
    .ch_resp_data(ch_resp_data), .ch_occupancy(ch_occupancy)
  );

  eu_lsu_arbiter #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .Flush(Flush), .kill_mask(kill_mask),
    .ch_req_valid(t3_req_valid), .ch_req_ready(t3_req_ready),
    .ch_req_data(t3_req_data), .ch_req_spectag(t3_req_spectag),
    .lsu_req_valid(t3_lsu_valid), .lsu_req_ready(t3_lsu_ready),
    .lsu_req_data(t3_lsu_data), .lsu_req_ch(t3_lsu_ch),
    .lsu_resp_valid(t3_lsu_resp_valid), .lsu_resp_ch(t3_lsu_resp_ch),
    .lsu_resp_data(t3_lsu_resp_data), .ch_resp_valid(t3_resp_valid),
    .ch_resp_data(t3_resp_data), .ch_occupancy(t3_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk(tag, 128'(exp_q.size()), 128'd0);
  endtask

  // Every LSU handshake must match the oldest expected request.
  always @(negedge clk) begin
    if (rst && lsu_req_valid && lsu_req_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 128'(lsu_req_data), 128'hDEAD);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_data", lsu_req_data, mon_e.data);
        chk("sb_ch", 128'(lsu_req_ch), 128'(mon_e.ch));
      end
    end
  end

  initial begin
    rst = 1'b0; Flush = 1'b0; kill_mask = '0;
    ch_req_valid = '0; ch_req_data = '0; ch_req_spectag = '0;
    lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0; lsu_resp_ch = '0; lsu_resp_data = '0;
    t3_req_valid = '0; t3_req_data = '0; t3_req_spectag = '0; t3_lsu_ready = 1'b0;
    t3_lsu_resp_valid = 1'b0; t3_lsu_resp_ch = '0; t3_lsu_resp_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_req_valid", 128'(lsu_req_valid), 128'd0);
    chk("rst_ready", 128'(ch_req_ready), 128'd0);
    chk("rst_occ", 128'(ch_occupancy), 128'd0);
    chk("rst_resp_valid", 128'(ch_resp_valid), 128'd0);
    rst = 1'b1;
    tick();
    chk("ready_after_rst", 128'(ch_req_ready), 128'h3);
    chk("rr_reset", 128'(dut.rr_ptr_q), 128'd0);

    // Simultaneous push on both channels, round-robin order
    lsu_req_ready = 1'b1;
    ch_req_valid = 2'b11;
    ch_req_data[127:0] = 128'hA; ch_req_data[255:128] = 128'hB;
    ch_req_spectag = 8'h11;
    exp_q.push_back('{ch: 1'b0, data: 128'hA});
    exp_q.push_back('{ch: 1'b1, data: 128'hB});
    tick();
    ch_req_valid = 2'b00;
    chk("lat_not_yet", 128'(lsu_req_valid), 128'd0);
    tick();
    chk("first_data", lsu_req_data, 128'hA);
    chk("rr_after_first", 128'(dut.rr_ptr_q), 128'd1);
    tick();
    chk("second_data", lsu_req_data, 128'hB);
    chk("rr_after_second", 128'(dut.rr_ptr_q), 128'd0);
    drain("drain_rr", 5);

    // Back-pressure: LSU stalls while ch0 pushes
    lsu_req_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      ch_req_valid = 2'b01;
      ch_req_data[127:0] = 128'h200 + 128'(i);
      ch_req_spectag = 8'h01;
      if (ch_req_ready[0]) begin
        accepted++;
        exp_q.push_back('{ch: 1'b0, data: 128'h200 + 128'(i)});
      end
      tick();
      if (i >= 1) chk("hold_data", lsu_req_data, 128'h200);
    end
    ch_req_valid = 2'b00;
    chk("bp_accepted", 128'(accepted), 128'd5);
    chk("bp_occ", 128'(ch_occupancy[2:0]), 128'd4);
    chk("bp_ready", 128'(ch_req_ready[0]), 128'd0);
    chk("bp_out_valid", 128'(lsu_req_valid), 128'd1);
    lsu_req_ready = 1'b1;
    drain("drain_bp", 12);
    tick();
    chk("bp_occ_empty", 128'(ch_occupancy[2:0]), 128'd0);

    // Speculative kill on ch1 with the LSU stalled
    lsu_req_ready = 1'b0;
    ch_req_valid = 2'b10;
    ch_req_data[255:128] = 128'h31; ch_req_spectag = 8'h10;
    tick();
    ch_req_data[255:128] = 128'h32; ch_req_spectag = 8'h20;
    exp_q.push_back('{ch: 1'b1, data: 128'h32});
    tick();
    ch_req_data[255:128] = 128'h33; ch_req_spectag = 8'h10;
    tick();
    ch_req_valid = 2'b00;
    kill_mask = 4'b0001;
    tick();
    kill_mask = '0;
    chk("kill_outreg", 128'(lsu_req_valid), 128'd0);
    tick(); tick(); tick();
    chk("kill_occ", 128'(ch_occupancy[5:3]), 128'd0);
    chk("kill_survivor", lsu_req_data, 128'h32);
    lsu_req_ready = 1'b1;
    drain("drain_kill", 5);

    // Enqueue and matching kill in the same cycle
    ch_req_valid = 2'b01; ch_req_data[127:0] = 128'h44; ch_req_spectag = 8'h04;
    kill_mask = 4'b0100;
    tick();
    ch_req_valid = 2'b00; kill_mask = '0;
    tick(); tick(); tick();
    chk("samecyc_kill_occ", 128'(ch_occupancy), 128'd0);
    chk("samecyc_kill_vld", 128'(lsu_req_valid), 128'd0);

    // Flush with buffered requests and a valid output
    lsu_req_ready = 1'b0;
    ch_req_valid = 2'b11; ch_req_data[127:0] = 128'h61; ch_req_data[255:128] = 128'h62;
    ch_req_spectag = 8'h11;
    tick();
    ch_req_valid = 2'b01; ch_req_data[127:0] = 128'h63;
    tick();
    ch_req_valid = 2'b00;
    lsu_resp_valid = 1'b1; lsu_resp_ch = 1'b0; lsu_resp_data = 96'h99;
    tick();
    chk("pre_flush_vld", 128'(lsu_req_valid), 128'd1);
    chk("pre_flush_resp", 128'(ch_resp_valid), 128'h1);
    chk("pre_flush_rdata", 128'(ch_resp_data), 128'h99);
    Flush = 1'b1;
    ch_req_valid = 2'b11;
    lsu_resp_ch = 1'b1; lsu_resp_data = 96'hAA;
    tick();
    Flush = 1'b0; ch_req_valid = 2'b00; lsu_resp_valid = 1'b0;
    chk("flush_vld", 128'(lsu_req_valid), 128'd0);
    chk("flush_data", lsu_req_data, 128'd0);
    chk("flush_ch", 128'(lsu_req_ch), 128'd0);
    chk("flush_resp_vld", 128'(ch_resp_valid), 128'd0);
    chk("flush_resp_data", 128'(ch_resp_data), 128'd0);
    chk("flush_occ", 128'(ch_occupancy), 128'd0);
    chk("flush_ready", 128'(ch_req_ready), 128'h3);
    lsu_req_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("flush_no_stale", 128'(lsu_req_valid), 128'd0);

    // Response routing
    lsu_resp_valid = 1'b1; lsu_resp_ch = 1'b1; lsu_resp_data = 96'h55;
    tick();
    lsu_resp_valid = 1'b0;
    chk("resp_strobe", 128'(ch_resp_valid), 128'h2);
    chk("resp_data", 128'(ch_resp_data), 128'h55);
    tick();
    chk("resp_one_cycle", 128'(ch_resp_valid), 128'd0);
    t3_lsu_resp_valid = 1'b1; t3_lsu_resp_ch = 2'd3; t3_lsu_resp_data = 96'h66;
    tick();
    chk("resp_tag_oor", 128'(t3_resp_valid), 128'd0);
    t3_lsu_resp_ch = 2'd2; t3_lsu_resp_data = 96'h77;
    tick();
    t3_lsu_resp_valid = 1'b0;
    chk("resp3_strobe", 128'(t3_resp_valid), 128'h4);
    chk("resp3_data", 128'(t3_resp_data), 128'h77);

    // Asynchronous reset in the middle of a burst
    lsu_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ch_req_valid = 2'b01; ch_req_data[127:0] = 128'h80 + 128'(i); ch_req_spectag = 8'h01;
      exp_q.push_back('{ch: 1'b0, data: 128'h80 + 128'(i)});
      tick();
    end
    ch_req_valid = 2'b00;
    #1 rst = 1'b0;
    #1;
    chk("arst_vld", 128'(lsu_req_valid), 128'd0);
    chk("arst_data", lsu_req_data, 128'd0);
    chk("arst_ready", 128'(ch_req_ready), 128'd0);
    chk("arst_occ", 128'(ch_occupancy), 128'd0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    chk("arst_ready_back", 128'(ch_req_ready), 128'h3);
    ch_req_valid = 2'b10; ch_req_data[255:128] = 128'h90; ch_req_spectag = 8'h10;
    exp_q.push_back('{ch: 1'b1, data: 128'h90});
    tick();
    ch_req_valid = 2'b00;
    drain("drain_after_rst", 6);

    tick();
    chk("sb_final_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
